// File: rtl/param_xform_pkg.sv
// Shared mode encodings and the per-item transform for the param_xform_pipe family.
// The transform works on a fixed maximum width; callers zero-extend and keep the low bits.
package param_xform_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_INC  = 2'b11;

  localparam int XFORM_MAX_W = 64;
  localparam int XFORM_IW    = $clog2(XFORM_MAX_W);

  // Only the low `width` bits of the result are meaningful.
  function automatic logic [XFORM_MAX_W-1:0] xform(
    input logic [1:0]             mode,
    input logic [XFORM_MAX_W-1:0] data,
    input int                     width
  );
    logic [XFORM_MAX_W-1:0] r;
    r = data;
    case (mode)
      MODE_INV: r = ~data;
      MODE_REV: begin
        r = '0;
        for (int i = 0; i < XFORM_MAX_W; i++) begin
          if (i < width) r[XFORM_IW'(width - 1 - i)] = data[i];
        end
      end
      MODE_INC: r = data + XFORM_MAX_W'(1);
      default:  r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xform_stage.sv
// One pipeline register slot: valid bit plus payload, advancing when it is empty
// or when its downstream takes the current item.
module xform_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             moving,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign moving = !valid || down_ready;

  // Payload only loads with a real item so a drained slot keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (moving) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/param_xform_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready pipeline applying a per-item transform at entry.
// Define XFORM_PARITY_EN to add the out_parity port (XOR of the presented payload).
module param_xform_pipe
  import param_xform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef XFORM_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [XFORM_MAX_W-1:0] in_ext;
  logic [XFORM_MAX_W-1:0] xf_full;
  logic                   unused_xf;
  logic [DEPTH:0]         ready_s;
  logic [DEPTH-1:0]       valid_s;
  logic [WIDTH-1:0]       data_s [DEPTH];
  logic                   in_xfer;
  logic                   out_xfer;

  always_comb begin
    in_ext             = '0;
    in_ext[WIDTH-1:0]  = in_data;
  end

  assign xf_full   = xform(in_mode, in_ext, WIDTH);
  assign unused_xf = ^xf_full;

  // Ready ripples combinationally from the consumer back to the producer.
  assign ready_s[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = xf_full[WIDTH-1:0];
    end else begin : g_body
      assign up_valid = valid_s[k-1];
      assign up_data  = data_s[k-1];
    end
    xform_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (ready_s[k+1]),
      .moving     (ready_s[k]),
      .valid      (valid_s[k]),
      .data       (data_s[k])
    );
  end

  assign in_ready  = rst_n && ready_s[0];
  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

`ifdef XFORM_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule

// File: doc/param_xform_pipe.md
# param_xform_pipe

Parametrised successor to the team's combinational bitwise inverter. It is a WIDTH-bit, DEPTH-stage pipelined transform unit with a valid/ready handshake on both sides and four selectable per-item modes, one of which is invert. It sits between a producer and a consumer that may stall, and carries data through a registered pipeline at one item per cycle.

## Interface
- WIDTH, 8, data width in bits; must be ≥1.
- DEPTH, 2, number of pipeline stages; must be ≥1. This is also the latency and the capacity.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: synchronous, active-low. One clock; all state is sampled on clk.
- in_valid  in  1  producer has an item.
- in_ready  out  1  block accepts the item this cycle.
- in_data  in  WIDTH  item payload.
- in_mode  in  2  transform selected for this item; sampled with in_data.
- out_valid  out  1  an item is presented.
- out_ready  in  1  consumer takes the item this cycle.
- out_data  out  WIDTH  transformed payload.
- occupancy  out  $clog2(DEPTH+1)  items currently held, in the range 0..DEPTH.
- out_parity  out  1  present only with XFORM_PARITY_EN; see Configuration.

## Operation
- An item transfers on the input side when in_valid && in_ready. It transfers on the output side when out_valid && out_ready.
- The transform is applied once, as the item enters stage 0. The result then travels unchanged to stage DEPTH-1.
- Modes:
  - 00 pass: the item is unchanged.
  - 01 invert: bitwise not.
  - 10 reverse: bit i moves to position WIDTH-1-i.
  - 11 increment: +1 modulo 2^WIDTH, so all-ones wraps to 0.
- Each stage holds a valid bit and a WIDTH-bit data register.
- Stage k loads from stage k-1 when it is empty or when it is emptying this cycle.
- Stall rule: stage k is "moving" when it is invalid, or when it is valid and its downstream accepts (stage k+1 moving, or out_ready for the last stage). in_ready equals "stage 0 moving". The ready chain is combinational from out_ready to in_ready.
- Items are never dropped, duplicated or reordered.
- Full condition: all DEPTH stages valid and out_ready low, so in_ready is 0.
- Empty condition: out_valid is 0 and out_data holds its last value.
- occupancy is +1 on an input transfer and -1 on an output transfer. A simultaneous input and output transfer leaves it unchanged.
- Reset: while rst_n is low at a clk edge, all valid bits, data registers and occupancy clear to 0.
  - Reset mid-stream discards every in-flight item.
  - While in reset, in_ready is 0.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, in_ready=0. in_ready becomes 1 on the first cycle with rst_n high.
- Latency: an item accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, so it is visible for a transfer at edge N+DEPTH. This assumes no stall.
- Throughput: one item per cycle while out_ready stays high.
- Stall: while out_ready is low, out_valid and out_data hold stable until taken. Upstream stages keep filling bubbles until the pipeline is full.
- in_mode and in_data matter only in the cycle of the input transfer.

## Configuration
- XFORM_PARITY_EN defined: the out_parity port exists and equals the XOR-reduction of the stored out_data.
  - It is registered with the data, so it has the same latency and the same stall/hold behaviour.
  - Its reset value is 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package param_xform_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_INV=2'b01, MODE_REV=2'b10, MODE_INC=2'b11;
  - a transform function (mode, data) → data, parametrised by WIDTH through an argument or a width-generic implementation.
- Sub-module xform_stage is one valid/data register with moving/load logic. It is instantiated DEPTH times via generate. The top level holds the transform, the occupancy counter and the parity logic.

## Test plan
All scenarios use WIDTH=4 and DEPTH=2 unless noted.
- Invert, free flow: in_data=4'b0011, mode 01, out_ready=1 → out_data=4'b1100 with out_valid two edges after acceptance; occupancy peaks at 1.
- Modes: reverse 4'b0001 → 4'b1000; increment 4'b1111 → 4'b0000 (wrap); pass 4'b1010 → 4'b1010.
- Backpressure: out_ready=0 and feed 0,1,2 → exactly 2 accepted, in_ready=0, occupancy=2, out_data stable. Raise out_ready → outputs 0 then 1 in order, then 2 is accepted.
- Streaming: values 0..15 in mode 01 back-to-back with out_ready=1 → outputs 15..0 on 16 consecutive cycles; occupancy constant at 2 mid-stream.
- Reset mid-stream with occupancy=2: hold rst_n low for one edge → out_valid=0, occupancy=0, no stale item is output afterwards.
- Parity, XFORM_PARITY_EN defined: output 4'b0111 → out_parity=1; output 4'b1100 → out_parity=0.
